// File: rtl/bsg_mem_1r1w_sync_ctrl.sv
// bsg_mem_1r1w_sync_ctrl: shares one 1R1W synchronous memory between num_req_p requesters.
// Independent round-robin arbiters for the write and read ports. The read response goes back
// to the granted requester one cycle later. The memory is zero-filled after reset. A read and a
// write to the same address in the same cycle never reach the memory: the write wins and the
// read is retried.
// Optional build macro BSG_MEM_1R1W_SYNC_CTRL_STATS_EN adds saturating grant/collision counters.
module bsg_mem_1r1w_sync_ctrl #(
  // Defaults exist only so the block elaborates standalone; instantiators set these.
  parameter int unsigned width_p   = 8,
  parameter int unsigned els_p     = 8,
  parameter int unsigned num_req_p = 2,
  localparam int unsigned addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                               clk_i,
  input  logic                               reset_n_i,

  input  logic [num_req_p-1:0]               w_v_i,
  input  logic [num_req_p*addr_width_lp-1:0] w_addr_i,
  input  logic [num_req_p*width_p-1:0]       w_data_i,
  output logic [num_req_p-1:0]               w_ready_o,

  input  logic [num_req_p-1:0]               r_v_i,
  input  logic [num_req_p*addr_width_lp-1:0] r_addr_i,
  output logic [num_req_p-1:0]               r_ready_o,
  output logic [num_req_p-1:0]               r_v_o,
  output logic [width_p-1:0]                 r_data_o,

  output logic                               mem_w_v_o,
  output logic [addr_width_lp-1:0]           mem_w_addr_o,
  output logic [width_p-1:0]                 mem_w_data_o,
  output logic                               mem_r_v_o,
  output logic [addr_width_lp-1:0]           mem_r_addr_o,
  input  logic [width_p-1:0]                 mem_r_data_i,

`ifdef BSG_MEM_1R1W_SYNC_CTRL_STATS_EN
  output logic [31:0]                        stat_w_grants_o,
  output logic [31:0]                        stat_r_grants_o,
  output logic [31:0]                        stat_collisions_o,
`endif
  output logic                               init_done_o
);

  localparam int unsigned ptr_width_lp = $clog2(num_req_p);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e                    state_q;
  logic [addr_width_lp-1:0]  fill_addr_q;
  logic [ptr_width_lp-1:0]   wptr_q;
  logic [ptr_width_lp-1:0]   rptr_q;
  logic [num_req_p-1:0]      r_v_q;

  logic                      init_c;
  logic                      run_c;
  logic                      w_found;
  logic [ptr_width_lp-1:0]   w_sel;
  logic                      r_found;
  logic [ptr_width_lp-1:0]   r_sel;
  logic [addr_width_lp-1:0]  w_addr_sel;
  logic [width_p-1:0]        w_data_sel;
  logic [addr_width_lp-1:0]  r_addr_sel;
  logic                      w_grant;
  logic                      r_grant;
  logic                      collide;

  // Round-robin search: first set bit of v starting at ptr and wrapping. Returns {found, index}.
  function automatic logic [ptr_width_lp:0] rr_pick(input logic [num_req_p-1:0]    v,
                                                    input logic [ptr_width_lp-1:0] ptr);
    logic [ptr_width_lp:0] res;
    int unsigned           idx;
    res = '0;
    for (int unsigned k = 0; k < num_req_p; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= num_req_p) idx = idx - num_req_p;
      if (!res[ptr_width_lp] && v[ptr_width_lp'(idx)]) res = {1'b1, ptr_width_lp'(idx)};
    end
    return res;
  endfunction

  // Pointer advance past the granted requester, wrapping at num_req_p.
  function automatic logic [ptr_width_lp-1:0] next_ptr(input logic [ptr_width_lp-1:0] sel);
    return (32'(sel) == num_req_p - 1) ? '0 : sel + ptr_width_lp'(1);
  endfunction

  // Arbitration, collision suppression and memory port steering.
  always_comb begin
    init_c       = reset_n_i && (state_q == ST_INIT);
    run_c        = reset_n_i && (state_q == ST_RUN);

    {w_found, w_sel} = rr_pick(w_v_i, wptr_q);
    {r_found, r_sel} = rr_pick(r_v_i, rptr_q);

    w_addr_sel   = w_addr_i[32'(w_sel) * addr_width_lp +: addr_width_lp];
    w_data_sel   = w_data_i[32'(w_sel) * width_p +: width_p];
    r_addr_sel   = r_addr_i[32'(r_sel) * addr_width_lp +: addr_width_lp];

    w_grant      = run_c && w_found;
    // The candidate read is dropped (not replaced by another requester) when it hits the write.
    collide      = w_grant && r_found && (r_addr_sel == w_addr_sel);
    r_grant      = run_c && r_found && !collide;

    w_ready_o    = w_grant ? (num_req_p'(1) << w_sel) : '0;
    r_ready_o    = r_grant ? (num_req_p'(1) << r_sel) : '0;

    mem_w_v_o    = init_c || w_grant;
    mem_w_addr_o = init_c ? fill_addr_q : w_addr_sel;
    mem_w_data_o = init_c ? '0 : w_data_sel;

    mem_r_v_o    = r_grant;
    mem_r_addr_o = r_addr_sel;

    init_done_o  = run_c;
  end

  // Response valid is held low while reset is asserted so no stale response escapes.
  assign r_v_o    = r_v_q & {num_req_p{reset_n_i}};
  assign r_data_o = mem_r_data_i;

  // Zero-fill sequencing, round-robin pointers and read-response valid.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q     <= ST_INIT;
      fill_addr_q <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      r_v_q       <= '0;
    end else begin
      r_v_q <= r_grant ? (num_req_p'(1) << r_sel) : '0;
      case (state_q)
        ST_INIT: begin
          fill_addr_q <= fill_addr_q + addr_width_lp'(1);
          if (fill_addr_q == addr_width_lp'(els_p - 1)) state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (w_grant) wptr_q <= next_ptr(w_sel);
          if (r_grant) rptr_q <= next_ptr(r_sel);
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

`ifdef BSG_MEM_1R1W_SYNC_CTRL_STATS_EN
  // Saturating usage counters; grants and collisions only occur in RUN.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      stat_w_grants_o   <= '0;
      stat_r_grants_o   <= '0;
      stat_collisions_o <= '0;
    end else begin
      if (w_grant && (stat_w_grants_o != '1))   stat_w_grants_o   <= stat_w_grants_o + 32'd1;
      if (r_grant && (stat_r_grants_o != '1))   stat_r_grants_o   <= stat_r_grants_o + 32'd1;
      if (collide && (stat_collisions_o != '1)) stat_collisions_o <= stat_collisions_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bsg_mem_1r1w_sync_ctrl.sv
// Bench for bsg_mem_1r1w_sync_ctrl: width 8, depth 8, two requesters, behavioural memory.
module tb_bsg_mem_1r1w_sync_ctrl;

  localparam int unsigned W  = 8;
  localparam int unsigned E  = 8;
  localparam int unsigned N  = 2;
  localparam int unsigned AW = 3;
  localparam int NV = 20;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    w_v;
  logic [N*AW-1:0] w_addr;
  logic [N*W-1:0]  w_data;
  logic [N-1:0]    w_ready;
  logic [N-1:0]    r_v;
  logic [N*AW-1:0] r_addr;
  logic [N-1:0]    r_ready;
  logic [N-1:0]    r_v_o;
  logic [W-1:0]    r_data;
  logic            mem_w_v;
  logic [AW-1:0]   mem_w_addr;
  logic [W-1:0]    mem_w_data;
  logic            mem_r_v;
  logic [AW-1:0]   mem_r_addr;
  logic [W-1:0]    mem_r_data;
  logic            init_done;
`ifdef BSG_MEM_1R1W_SYNC_CTRL_STATS_EN
  logic [31:0]     stat_w, stat_r, stat_c;
`endif

  bsg_mem_1r1w_sync_ctrl #(.width_p(W), .els_p(E), .num_req_p(N)) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .w_v_i(w_v), .w_addr_i(w_addr), .w_data_i(w_data), .w_ready_o(w_ready),
    .r_v_i(r_v), .r_addr_i(r_addr), .r_ready_o(r_ready), .r_v_o(r_v_o), .r_data_o(r_data),
    .mem_w_v_o(mem_w_v), .mem_w_addr_o(mem_w_addr), .mem_w_data_o(mem_w_data),
    .mem_r_v_o(mem_r_v), .mem_r_addr_o(mem_r_addr), .mem_r_data_i(mem_r_data),
`ifdef BSG_MEM_1R1W_SYNC_CTRL_STATS_EN
    .stat_w_grants_o(stat_w), .stat_r_grants_o(stat_r), .stat_collisions_o(stat_c),
`endif
    .init_done_o(init_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;
  int same_addr_hits = 0;

  // Behavioural memory; scrambled to 0xFF during reset so the zero-fill is observable.
  logic [W-1:0] mem [E];
  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(E); i++) mem[i] <= 8'hFF;
    end else begin
      if (mem_w_v) mem[mem_w_addr] <= mem_w_data;
      if (mem_r_v) mem_r_data <= mem[mem_r_addr];
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (reset_n && mem_w_v && mem_r_v && (mem_w_addr == mem_r_addr)) same_addr_hits++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard of expected read responses, each due on a specific cycle.
  typedef struct packed {
    logic [N-1:0] v;
    logic [W-1:0] d;
    int unsigned  due;
  } resp_t;
  resp_t exp_q[$];

  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      resp_t e;
      e = exp_q.pop_front();
      check("resp_v", 32'(r_v_o), 32'(e.v));
      check("resp_data", 32'(r_data), 32'(e.d));
    end else if (r_v_o !== '0) begin
      check("resp_unexpected", 32'(r_v_o), 32'd0);
    end
  end

  typedef struct packed {
    logic [1:0] wv;
    logic [2:0] wa0, wa1;
    logic [7:0] wd0, wd1;
    logic [1:0] rv;
    logic [2:0] ra0, ra1;
    logic [1:0] ewr, err;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] wv, input logic [2:0] wa0, input logic [2:0] wa1,
                              input logic [7:0] wd0, input logic [7:0] wd1, input logic [1:0] rv,
                              input logic [2:0] ra0, input logic [2:0] ra1,
                              input logic [1:0] ewr, input logic [1:0] err);
    vec_t v;
    v.wv = wv; v.wa0 = wa0; v.wa1 = wa1; v.wd0 = wd0; v.wd1 = wd1;
    v.rv = rv; v.ra0 = ra0; v.ra1 = ra1; v.ewr = ewr; v.err = err;
    return v;
  endfunction

  // One cycle: drive after the edge, return at the following negedge for sampling.
  task automatic drive(input vec_t v, input logic rn);
    @(posedge clk);
    #1;
    reset_n = rn;
    w_v     = v.wv;
    w_addr  = {v.wa1, v.wa0};
    w_data  = {v.wd1, v.wd0};
    r_v     = v.rv;
    r_addr  = {v.ra1, v.ra0};
    @(negedge clk);
  endtask

  vec_t         vecs [NV];
  vec_t         idle, busy, v;
  logic [W-1:0] shadow [E];
  logic [AW-1:0] a;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    w_v = '0; w_addr = '0; w_data = '0; r_v = '0; r_addr = '0;
    for (int i = 0; i < int'(E); i++) shadow[i] = '0;
    idle = '0;
    busy = mk(2'b11, 3'd0, 3'd1, 8'h01, 8'h02, 2'b11, 3'd2, 3'd3, 2'b00, 2'b00);

    vecs[0]  = mk(2'b11, 3'd1, 3'd2, 8'h11, 8'h22, 2'b00, 3'd0, 3'd0, 2'b01, 2'b00);
    vecs[1]  = mk(2'b11, 3'd1, 3'd2, 8'h11, 8'h22, 2'b00, 3'd0, 3'd0, 2'b10, 2'b00);
    vecs[2]  = mk(2'b11, 3'd1, 3'd2, 8'h11, 8'h22, 2'b00, 3'd0, 3'd0, 2'b01, 2'b00);
    vecs[3]  = mk(2'b11, 3'd1, 3'd2, 8'h11, 8'h22, 2'b00, 3'd0, 3'd0, 2'b10, 2'b00);
    vecs[4]  = mk(2'b01, 3'd3, 3'd0, 8'hA5, 8'h00, 2'b00, 3'd0, 3'd0, 2'b01, 2'b00);
    vecs[5]  = mk(2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b10, 3'd0, 3'd3, 2'b00, 2'b10);
    vecs[6]  = idle;
    vecs[7]  = mk(2'b01, 3'd5, 3'd0, 8'h3C, 8'h00, 2'b10, 3'd0, 3'd5, 2'b01, 2'b00);
    vecs[8]  = mk(2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b10, 3'd0, 3'd5, 2'b00, 2'b10);
    vecs[9]  = idle;
    vecs[10] = mk(2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b11, 3'd1, 3'd2, 2'b00, 2'b01);
    vecs[11] = mk(2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b11, 3'd1, 3'd2, 2'b00, 2'b10);
    vecs[12] = mk(2'b10, 3'd0, 3'd7, 8'h00, 8'h77, 2'b10, 3'd0, 3'd0, 2'b10, 2'b10);
    vecs[13] = mk(2'b01, 3'd4, 3'd0, 8'h44, 8'h00, 2'b11, 3'd4, 3'd6, 2'b01, 2'b00);
    vecs[14] = mk(2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b11, 3'd4, 3'd6, 2'b00, 2'b01);
    vecs[15] = mk(2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b10, 3'd4, 3'd6, 2'b00, 2'b10);
    vecs[16] = mk(2'b11, 3'd6, 3'd7, 8'h66, 8'h88, 2'b01, 3'd7, 3'd0, 2'b10, 2'b00);
    vecs[17] = mk(2'b01, 3'd6, 3'd0, 8'h66, 8'h00, 2'b01, 3'd7, 3'd0, 2'b01, 2'b01);
    vecs[18] = mk(2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b01, 3'd6, 3'd0, 2'b00, 2'b01);
    vecs[19] = idle;

    // Reset: everything quiet even with requests present.
    drive(busy, 1'b0);
    drive(busy, 1'b0);
    check("rst w_ready", 32'(w_ready), 32'd0);
    check("rst r_ready", 32'(r_ready), 32'd0);
    check("rst r_v_o", 32'(r_v_o), 32'd0);
    check("rst mem_r_v", 32'(mem_r_v), 32'd0);
    check("rst init_done", 32'(init_done), 32'd0);

    // Zero-fill: els_p cycles of writes 0..7, no grants, then init_done.
    for (int i = 0; i < int'(E); i++) begin
      drive(busy, 1'b1);
      check($sformatf("init%0d mem_w_v", i), 32'(mem_w_v), 32'd1);
      check($sformatf("init%0d mem_w_addr", i), 32'(mem_w_addr), 32'(i));
      check($sformatf("init%0d mem_w_data", i), 32'(mem_w_data), 32'd0);
      check($sformatf("init%0d grants", i), 32'({w_ready, r_ready, mem_r_v}), 32'd0);
      check($sformatf("init%0d init_done", i), 32'(init_done), 32'd0);
    end
    drive(idle, 1'b1);
    check("run init_done", 32'(init_done), 32'd1);

    // Table: arbitration, collisions and read-back through the scoreboard.
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i], 1'b1);
      check($sformatf("v%0d w_ready", i), 32'(w_ready), 32'(vecs[i].ewr));
      check($sformatf("v%0d r_ready", i), 32'(r_ready), 32'(vecs[i].err));
      check($sformatf("v%0d mem_w_v", i), 32'(mem_w_v), 32'(vecs[i].ewr != 2'b00));
      check($sformatf("v%0d mem_r_v", i), 32'(mem_r_v), 32'(vecs[i].err != 2'b00));
      if (vecs[i].err != 2'b00) begin
        a = vecs[i].err[1] ? vecs[i].ra1 : vecs[i].ra0;
        check($sformatf("v%0d mem_r_addr", i), 32'(mem_r_addr), 32'(a));
        exp_q.push_back('{v: vecs[i].err, d: shadow[a], due: cyc + 1});
      end
      if (vecs[i].ewr != 2'b00) begin
        a = vecs[i].ewr[1] ? vecs[i].wa1 : vecs[i].wa0;
        check($sformatf("v%0d mem_w_addr", i), 32'(mem_w_addr), 32'(a));
        check($sformatf("v%0d mem_w_data", i), 32'(mem_w_data),
              32'(vecs[i].ewr[1] ? vecs[i].wd1 : vecs[i].wd0));
        shadow[a] = vecs[i].ewr[1] ? vecs[i].wd1 : vecs[i].wd0;
      end
    end

`ifdef BSG_MEM_1R1W_SYNC_CTRL_STATS_EN
    check("stat_w_grants", stat_w, 32'd10);
    check("stat_r_grants", stat_r, 32'd9);
    check("stat_collisions", stat_c, 32'd3);
`endif

    // Read granted, then reset: the in-flight response must be dropped and INIT restarts.
    v = mk(2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b01, 3'd0, 3'd0, 2'b00, 2'b00);
    drive(v, 1'b1);
    check("pre-rst r_ready", 32'(r_ready), 32'b01);
    drive(idle, 1'b0);
    check("rst drop r_v_o", 32'(r_v_o), 32'd0);
    drive(idle, 1'b1);
    check("post-rst r_v_o", 32'(r_v_o), 32'd0);
    check("reinit mem_w_v", 32'(mem_w_v), 32'd1);
    check("reinit addr0", 32'(mem_w_addr), 32'd0);
    for (int i = 1; i < 4; i++) begin
      drive(busy, 1'b1);
      check($sformatf("reinit addr%0d", i), 32'(mem_w_addr), 32'(i));
    end

    // One-cycle reset at fill address 4: a full fill follows.
    drive(busy, 1'b0);
    check("midinit rst ready", 32'({w_ready, r_ready}), 32'd0);
    check("midinit rst init_done", 32'(init_done), 32'd0);
    for (int i = 0; i < int'(E); i++) begin
      drive(busy, 1'b1);
      check($sformatf("refill%0d mem_w_v", i), 32'(mem_w_v), 32'd1);
      check($sformatf("refill%0d addr", i), 32'(mem_w_addr), 32'(i));
      check($sformatf("refill%0d init_done", i), 32'(init_done), 32'd0);
    end
    drive(idle, 1'b1);
    check("refill init_done", 32'(init_done), 32'd1);
`ifdef BSG_MEM_1R1W_SYNC_CTRL_STATS_EN
    check("stat cleared", stat_w | stat_r | stat_c, 32'd0);
`endif

    // After re-fill, memory scrambled during reset must read back as zero.
    v = mk(2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b10, 3'd0, 3'd3, 2'b00, 2'b00);
    drive(v, 1'b1);
    check("refill r_ready", 32'(r_ready), 32'b10);
    if (r_ready == 2'b10) exp_q.push_back('{v: 2'b10, d: 8'h00, due: cyc + 1});
    drive(idle, 1'b1);
    drive(idle, 1'b1);

    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    check("same-addr r/w at memory", 32'(same_addr_hits), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
